// File: rtl/result_writeback_if.sv
// result_writeback_if: job, tile and RAM-write signals of the write-back stage
//   start/cfg_*            job launch and configuration (latched on start)
//   res_valid/res_data     tile in from the GEMM array, res_ready back
//   mem_en/we/addr/wdata   one RAM write per cycle out, mem_ready back
//   busy/done              job status
// master drives the job and tiles; slave is the write-back stage.
interface result_writeback_if #(
    parameter int DATA_W = 32,
    parameter int LANES  = 8,
    parameter int ADDR_W = 16
);
    logic                    start;
    logic [ADDR_W-1:0]       cfg_base_addr;
    logic [ADDR_W-1:0]       cfg_feat_size;
    logic [ADDR_W-1:0]       cfg_num_kernels;
    logic                    cfg_order;
    logic                    cfg_relu;
    logic                    res_valid;
    logic [LANES*DATA_W-1:0] res_data;
    logic                    res_ready;
    logic                    mem_en;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic                    mem_ready;
    logic                    busy;
    logic                    done;

    modport master (
        output start, cfg_base_addr, cfg_feat_size, cfg_num_kernels, cfg_order, cfg_relu,
        output res_valid, res_data, mem_ready,
        input  res_ready, mem_en, mem_we, mem_addr, mem_wdata, busy, done
    );

    modport slave (
        input  start, cfg_base_addr, cfg_feat_size, cfg_num_kernels, cfg_order, cfg_relu,
        input  res_valid, res_data, mem_ready,
        output res_ready, mem_en, mem_we, mem_addr, mem_wdata, busy, done
    );
endinterface

// File: rtl/result_writeback.sv
// result_writeback: buffers GEMM result tiles in a FIFO and serialises them into masked RAM writes
//   clk, rst : clock and synchronous active-high reset
//   bus      : result_writeback_if.slave (job handshake, tile input, RAM write port)
module result_writeback #(
    parameter int DATA_W     = 32,
    parameter int LANES      = 8,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    result_writeback_if.slave bus
);
    localparam int LW = $clog2(LANES);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       base_q, f_q, kn_q;
    logic                    order_q, relu_q;
    logic [CW-1:0]           tn_q, total_q, acc_q, pos_t_q;
    logic [ADDR_W-1:0]       pos_k_q;
    logic [LANES*DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW:0]             wr_q, rd_q;
    logic [LANES*DATA_W-1:0] tile_q;
    logic                    sv_valid_q, sv_final_q;
    logic [LW-1:0]           lane_q, lane_last_q;
    logic [ADDR_W-1:0]       tile_addr_q;
    logic                    mem_we_q, out_last_q, fin_q;
    logic [ADDR_W-1:0]       mem_addr_q;
    logic [DATA_W-1:0]       mem_wdata_q;

    logic                    start_ok, job_empty, full, empty, push, pop;
    logic                    out_free, adv, lane_end, pos_last_t, pos_last_k;
    logic [CW-1:0]           tn_d;
    logic [ADDR_W-1:0]       kf, tl, load_addr;
    logic [DATA_W-1:0]       elem;

    assign start_ok   = state_q == IDLE && bus.start;
    assign job_empty  = bus.cfg_feat_size == '0 || bus.cfg_num_kernels == '0;
    assign tn_d       = ({1'b0, bus.cfg_feat_size} + CW'(LANES - 1)) >> LW;

    // Extra pointer bit distinguishes full from empty.
    assign full       = wr_q[PW] != rd_q[PW] && wr_q[PW-1:0] == rd_q[PW-1:0];
    assign empty      = wr_q == rd_q;
    assign push       = bus.res_valid && bus.res_ready;

    // The output register is the RAM-facing stage; it only takes a new lane once the held write is accepted.
    assign out_free   = !mem_we_q || bus.mem_ready;
    assign adv        = sv_valid_q && out_free;
    assign lane_end   = adv && lane_q == lane_last_q;
    assign pop        = !empty && (!sv_valid_q || lane_end);

    // Position of the tile about to be popped from the FIFO.
    assign pos_last_t = pos_t_q == tn_q - 1'b1;
    assign pos_last_k = pos_k_q == kn_q - 1'b1;
    assign kf         = pos_k_q * f_q;
    assign tl         = ADDR_W'(pos_t_q << LW);
    assign load_addr  = base_q + kf + tl;
    assign elem       = tile_q[lane_q * DATA_W +: DATA_W];

    assign bus.res_ready = state_q == RUN && !full && acc_q < total_q;
    assign bus.busy      = state_q != IDLE;
    assign bus.mem_en    = state_q != IDLE;
    assign bus.done      = state_q == DONE;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // RUN waits one cycle after the final write is accepted (fin_q) before signalling DONE.
    always_comb begin
        state_d = state_q;
        if (start_ok)
            state_d = job_empty ? DONE : RUN;
        else if (state_q == RUN && fin_q)
            state_d = DONE;
        else if (state_q == DONE)
            state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_q[PW-1:0]] <= bus.res_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            f_q         <= '0;
            kn_q        <= '0;
            order_q     <= 1'b0;
            relu_q      <= 1'b0;
            tn_q        <= '0;
            total_q     <= '0;
            acc_q       <= '0;
            pos_t_q     <= '0;
            pos_k_q     <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            tile_q      <= '0;
            sv_valid_q  <= 1'b0;
            sv_final_q  <= 1'b0;
            lane_q      <= '0;
            lane_last_q <= '0;
            tile_addr_q <= '0;
            mem_we_q    <= 1'b0;
            out_last_q  <= 1'b0;
            fin_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                base_q  <= bus.cfg_base_addr;
                f_q     <= bus.cfg_feat_size;
                kn_q    <= bus.cfg_num_kernels;
                order_q <= bus.cfg_order;
                relu_q  <= bus.cfg_relu;
                tn_q    <= tn_d;
                total_q <= tn_d * {1'b0, bus.cfg_num_kernels};
                acc_q   <= '0;
                pos_t_q <= '0;
                pos_k_q <= '0;
                fin_q   <= 1'b0;
            end else begin
                if (push)
                    acc_q <= acc_q + 1'b1;
                if (mem_we_q && bus.mem_ready && out_last_q)
                    fin_q <= 1'b1;
            end
            if (push)
                wr_q <= wr_q + 1'b1;
            if (pop) begin
                rd_q        <= rd_q + 1'b1;
                tile_q      <= fifo_mem[rd_q[PW-1:0]];
                sv_valid_q  <= 1'b1;
                lane_q      <= '0;
                // Only the last tile of a channel is partial; its last valid lane is (F-1) mod LANES.
                lane_last_q <= pos_last_t ? f_q[LW-1:0] - 1'b1 : {LW{1'b1}};
                sv_final_q  <= pos_last_t && pos_last_k;
                tile_addr_q <= load_addr;
                if (!order_q) begin
                    pos_t_q <= pos_last_t ? '0 : pos_t_q + 1'b1;
                    pos_k_q <= pos_last_t ? pos_k_q + 1'b1 : pos_k_q;
                end else begin
                    pos_k_q <= pos_last_k ? '0 : pos_k_q + 1'b1;
                    pos_t_q <= pos_last_k ? pos_t_q + 1'b1 : pos_t_q;
                end
            end else if (lane_end) begin
                sv_valid_q <= 1'b0;
            end else if (adv) begin
                lane_q <= lane_q + 1'b1;
            end
            if (out_free) begin
                mem_we_q   <= sv_valid_q;
                out_last_q <= lane_end && sv_final_q;
                if (sv_valid_q) begin
                    mem_addr_q  <= tile_addr_q + ADDR_W'(lane_q);
                    mem_wdata_q <= (relu_q && elem[DATA_W-1]) ? '0 : elem;
                end
            end
        end
    end
endmodule
